// File: rtl/dsp_common_pkg.sv
// Shared definitions for the chunked-processor front end: capture FSM
// states, I2S channel encodings and default buffer geometry.
package dsp_common_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  localparam int DEF_SAMPLE_SIZE  = 24;
  localparam int DEF_IO_BUFF_SIZE = 64;

endpackage

// File: rtl/i2s_chunk_capture_if.sv
// Processor-facing side of the capture stage: chunk handshake, read port
// of the ping-pong input buffer and status.
interface i2s_chunk_capture_if #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_PTR_BITS = 6
);

  logic                        proc_busy;
  logic                        chunk_pulse;
  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr;
  logic [SAMPLE_SIZE-1:0]      input_buff_sample;
  logic                        read_bank;
  logic                        overrun;

  // Capture stage side.
  modport master (
    input  proc_busy,
    input  input_buff_ptr,
    output chunk_pulse,
    output input_buff_sample,
    output read_bank,
    output overrun
  );

  // Processor side.
  modport slave (
    output proc_busy,
    output input_buff_ptr,
    input  chunk_pulse,
    input  input_buff_sample,
    input  read_bank,
    input  overrun
  );

endinterface

// File: rtl/i2s_rx_deser.sv
// I2S (Philips) receiver front end: pin synchronisers, bclk edge detection
// and an MSB-first shift register emitting one word per completed slot.
module i2s_rx_deser #(
  parameter int SAMPLE_SIZE = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_sdata,
  output logic [SAMPLE_SIZE-1:0] word,
  output logic                   word_valid,
  output logic                   word_channel,
  output logic                   slot_start
);

  localparam int CNT_BITS = $clog2(SAMPLE_SIZE + 1);
  localparam logic [SAMPLE_SIZE-1:0] MSB_ONE = {1'b1, {(SAMPLE_SIZE-1){1'b0}}};
  localparam logic [CNT_BITS-1:0]    CNT_FULL = CNT_BITS'(SAMPLE_SIZE);

  logic [2:0]             bclk_sync_q, bclk_sync_d;
  logic [1:0]             lrclk_sync_q, lrclk_sync_d;
  logic [1:0]             sdata_sync_q, sdata_sync_d;
  logic                   bclk_rise_q, bclk_rise_d;
  logic                   lr_prev_q, lr_prev_d;
  logic [CNT_BITS-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_SIZE-1:0] shift_q, shift_d, shift_cur;
  logic [SAMPLE_SIZE-1:0] word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic                   word_channel_q, word_channel_d;
  logic                   slot_start_q, slot_start_d;

  // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bclk_sync_d    = {bclk_sync_q[1:0], i2s_bclk};
    lrclk_sync_d   = {lrclk_sync_q[0], i2s_lrclk};
    sdata_sync_d   = {sdata_sync_q[0], i2s_sdata};
    bclk_rise_d    = bclk_sync_q[1] & ~bclk_sync_q[2];
    lr_prev_d      = lr_prev_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    word_d         = word_q;
    word_valid_d   = 1'b0;
    word_channel_d = word_channel_q;
    slot_start_d   = 1'b0;
    // Bits past SAMPLE_SIZE shift the marker out and drop; short slots leave zero LSBs.
    shift_cur = shift_q | ({SAMPLE_SIZE{sdata_sync_q[1]}} & (MSB_ONE >> bit_cnt_q));

    if (bclk_rise_q) begin
      lr_prev_d = lrclk_sync_q[1];
      if (lrclk_sync_q[1] != lr_prev_q) begin
        // Philips framing: the bit sampled just after a word-select change is the old slot's LSB.
        word_d         = shift_cur;
        word_valid_d   = 1'b1;
        word_channel_d = lr_prev_q;
        slot_start_d   = 1'b1;
        shift_d        = '0;
        bit_cnt_d      = '0;
      end else begin
        shift_d = shift_cur;
        if (bit_cnt_q != CNT_FULL) bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q    <= '0;
      lrclk_sync_q   <= '0;
      sdata_sync_q   <= '0;
      bclk_rise_q    <= 1'b0;
      lr_prev_q      <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      word_q         <= '0;
      word_valid_q   <= 1'b0;
      word_channel_q <= 1'b0;
      slot_start_q   <= 1'b0;
    end else begin
      bclk_sync_q    <= bclk_sync_d;
      lrclk_sync_q   <= lrclk_sync_d;
      sdata_sync_q   <= sdata_sync_d;
      bclk_rise_q    <= bclk_rise_d;
      lr_prev_q      <= lr_prev_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      word_q         <= word_d;
      word_valid_q   <= word_valid_d;
      word_channel_q <= word_channel_d;
      slot_start_q   <= slot_start_d;
    end
  end

  assign word         = word_q;
  assign word_valid   = word_valid_q;
  assign word_channel = word_channel_q;
  assign slot_start   = slot_start_q;

endmodule

// File: rtl/i2s_chunk_capture.sv
// I2S single-channel capture into a ping-pong buffer; each filled bank is
// handed to the processor with a one-cycle chunk pulse.
module i2s_chunk_capture
  import dsp_common_pkg::*;
#(
  parameter int SAMPLE_SIZE      = DEF_SAMPLE_SIZE,
  parameter int IO_BUFF_SIZE     = DEF_IO_BUFF_SIZE,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
  parameter int CHANNEL          = int'(CH_LEFT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic i2s_bclk,
  input  logic i2s_lrclk,
  input  logic i2s_sdata,
  i2s_chunk_capture_if.master bus
);

  localparam int   DEPTH  = 2 * IO_BUFF_SIZE;
  localparam logic CAP_CH = (CHANNEL != 0);
  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_PTR = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

  logic [SAMPLE_SIZE-1:0] word;
  logic                   word_valid;
  logic                   word_channel;
  logic                   slot_start;

  i2s_rx_deser #(.SAMPLE_SIZE(SAMPLE_SIZE)) u_deser (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .word         (word),
    .word_valid   (word_valid),
    .word_channel (word_channel),
    .slot_start   (slot_start)
  );

  cap_state_e                  state_q, state_d;
  logic [IO_BUFF_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic                        read_bank_q, read_bank_d;
  logic                        chunk_pulse_q, chunk_pulse_d;
  logic                        overrun_q, overrun_d;
  logic [SAMPLE_SIZE-1:0]      rd_data_q, rd_data_d;
  logic                        wr_en;
  logic                        own_word, own_slot_start;
  logic [IO_BUFF_PTR_BITS:0]   wr_addr, rd_addr;
  logic [SAMPLE_SIZE-1:0]      mem [DEPTH];

  assign own_word       = word_valid && (word_channel == CAP_CH);
  // word_channel names the slot that just ended, so our slot begins when the other one ends.
  assign own_slot_start = slot_start && (word_channel != CAP_CH);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    read_bank_d   = read_bank_q;
    chunk_pulse_d = 1'b0;
    overrun_d     = overrun_q;
    wr_en         = 1'b0;

    if (!enable) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_SYNC;
          wr_ptr_d = '0;
        end
        ST_SYNC: begin
          if (own_slot_start) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (own_word) begin
            wr_en = 1'b1;
            if (wr_ptr_q == LAST_PTR) begin
              wr_ptr_d      = '0;
              read_bank_d   = ~read_bank_q;
              chunk_pulse_d = 1'b1;
              overrun_d     = overrun_q | bus.proc_busy;
            end else begin
              wr_ptr_d = wr_ptr_q + IO_BUFF_PTR_BITS'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign wr_addr = {~read_bank_q, wr_ptr_q};
  // Reading through read_bank_d lets the pulse cycle already show the new bank.
  assign rd_addr = {read_bank_d, bus.input_buff_ptr};

  always_comb begin
    rd_data_d = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) rd_data_d = word;
  end

  // NOTE: the sample memory has no reset; its contents are only meaningful once a bank has filled.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      read_bank_q   <= 1'b1;
      chunk_pulse_q <= 1'b0;
      overrun_q     <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      read_bank_q   <= read_bank_d;
      chunk_pulse_q <= chunk_pulse_d;
      overrun_q     <= overrun_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign bus.chunk_pulse       = chunk_pulse_q;
  assign bus.input_buff_sample = rd_data_q;
  assign bus.read_bank         = read_bank_q;
  assign bus.overrun           = overrun_q;

endmodule

// File: tb/tb_i2s_chunk_capture.sv
// Scoreboard bench for i2s_chunk_capture: left words are queued as they are
// driven and every filled bank is read back and compared on its chunk pulse.
module tb_i2s_chunk_capture;
  import dsp_common_pkg::*;

  localparam int SS        = 24;
  localparam int BUF       = 64;
  localparam int PB        = 6;
  localparam int CLK_HALF  = 5;
  localparam int BCLK_HALF = 40;

  logic clk = 1'b0;
  logic rst_n, enable, i2s_bclk, i2s_lrclk, i2s_sdata;

  i2s_chunk_capture_if #(.SAMPLE_SIZE(SS), .IO_BUFF_PTR_BITS(PB)) bus_if ();

  i2s_chunk_capture #(
    .SAMPLE_SIZE      (SS),
    .IO_BUFF_SIZE     (BUF),
    .IO_BUFF_PTR_BITS (PB),
    .CHANNEL          (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .bus       (bus_if)
  );

  always #CLK_HALF clk = ~clk;

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          pulse_cnt = 0;
  logic        exp_bank  = 1'b1;
  logic        exp_ovr   = 1'b0;
  logic [SS-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Stored value of an n-bit MSB-first slot: first 24 bits, zero-padded.
  function automatic logic [SS-1:0] exp_word(input logic [31:0] v, input int n);
    logic [63:0] t;
    t = {32'h0, v} << (64 - n);
    return t[63:40];
  endfunction

  task automatic bit_period(input logic lr, input logic d);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = d;
    #BCLK_HALF i2s_bclk = 1'b1;
    #BCLK_HALF;
  endtask

  // One left+right frame; word select changes one bit before each MSB.
  task automatic send_frame(input logic [31:0] lval, input int lbits,
                            input logic [31:0] rval, input int rbits,
                            input bit push, input int en_bit);
    if (push) exp_q.push_back(exp_word(lval, lbits));
    for (int i = 0; i < lbits; i++) begin
      if (i == en_bit) enable = 1'b1;
      bit_period(i == lbits - 1, lval[lbits-1-i]);
    end
    for (int i = 0; i < rbits; i++) bit_period(i != rbits - 1, rval[rbits-1-i]);
  endtask

  initial begin : monitor
    logic [SS-1:0] chunk [BUF];
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.chunk_pulse) begin
        pulse_cnt++;
        exp_bank = ~exp_bank;
        exp_ovr  = exp_ovr | bus_if.proc_busy;
        check("words_at_pulse", exp_q.size(), BUF);
        for (int i = 0; i < BUF; i++) chunk[i] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("read_bank", bus_if.read_bank, exp_bank);
        check("overrun", bus_if.overrun, exp_ovr);
        check("sample_at_pulse", bus_if.input_buff_sample, chunk[bus_if.input_buff_ptr]);
        for (int p = 0; p < BUF; p++) begin
          bus_if.input_buff_ptr = PB'(p);
          @(negedge clk);
          if (p == 0) check("pulse_width", bus_if.chunk_pulse, 0);
          check($sformatf("rd_ptr%0d_chunk%0d", p, pulse_cnt), bus_if.input_buff_sample, chunk[p]);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n                 = 1'b0;
    enable                = 1'b0;
    i2s_bclk              = 1'b1;
    i2s_lrclk             = 1'b1;
    i2s_sdata             = 1'b0;
    bus_if.proc_busy      = 1'b0;
    bus_if.input_buff_ptr = '1;
    repeat (3) @(negedge clk);
    check("rst_chunk_pulse", bus_if.chunk_pulse, 0);
    check("rst_sample", bus_if.input_buff_sample, 0);
    check("rst_read_bank", bus_if.read_bank, 1);
    check("rst_overrun", bus_if.overrun, 0);
    rst_n = 1'b1;

    // Idle traffic, then enable mid-left-slot: that partial word must be dropped.
    repeat (2) send_frame(32'h5A5A5A, 24, 32'hABCDEF, 24, 1'b0, -1);
    send_frame(32'h777777, 24, 32'hABCDEF, 24, 1'b0, 2);

    // 128 continuous words; odd slot lengths in the second chunk, busy at its swap.
    for (int k = 1; k <= 128; k++) begin
      if (k == 127) bus_if.proc_busy = 1'b1;
      case (k)
        70:      send_frame(32'h123456FF, 32, 32'hABCDEF01, 32, 1'b1, -1);
        71:      send_frame(32'h0000BEEF, 16, 32'h00001234, 16, 1'b1, -1);
        72:      send_frame(32'(k), 24, 32'hABCDEF, 24, 1'b1, -1);
        default: send_frame(32'(k), 24, $urandom, 2, 1'b1, -1);
      endcase
    end
    bus_if.proc_busy = 1'b0;
    check("pulses_after_128", pulse_cnt, 2);
    check("read_bank_after_128", bus_if.read_bank, 1);

    // 40 words, then drop enable: nothing may be handed over.
    for (int k = 0; k < 40; k++) begin
      send_frame(32'h400 + 32'(k), 24, $urandom, 2, 1'b1, -1);
      if (k == 0) check("overrun_sticky", bus_if.overrun, 1);
    end
    enable = 1'b0;
    exp_q.delete();
    send_frame(32'h999999, 24, $urandom, 2, 1'b0, 2);
    check("no_pulse_on_disable", pulse_cnt, 2);
    for (int k = 0; k < 64; k++) send_frame(32'h800 + 32'(k), 24, $urandom, 2, 1'b1, -1);
    check("pulses_after_reenable", pulse_cnt, 3);

    // Asynchronous reset after 30 words of a chunk.
    for (int k = 0; k < 30; k++) send_frame(32'hC00 + 32'(k), 24, $urandom, 2, 1'b1, -1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_chunk_pulse", bus_if.chunk_pulse, 0);
    check("midrst_sample", bus_if.input_buff_sample, 0);
    check("midrst_read_bank", bus_if.read_bank, 1);
    check("midrst_overrun", bus_if.overrun, 0);
    exp_bank = 1'b1;
    exp_ovr  = 1'b0;
    exp_q.delete();
    #20 rst_n = 1'b1;
    send_frame(32'hEEEEEE, 24, $urandom, 2, 1'b0, -1);
    for (int k = 0; k < 63; k++) send_frame(32'hD00 + 32'(k), 24, $urandom, 2, 1'b1, -1);
    check("no_pulse_at_63_after_rst", pulse_cnt, 3);
    send_frame(32'hD3F, 24, $urandom, 2, 1'b1, -1);
    repeat (100) @(negedge clk);
    check("pulses_total", pulse_cnt, 4);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_chunk_capture.md
# i2s_chunk_capture

Upstream capture stage for the chunked processor. Receives a standard I2S stream and extracts one channel. Deserialised samples are written into a two-bank (ping-pong) input buffer. Each time a bank fills with IO_BUFF_SIZE samples, the banks swap and a one-cycle chunk pulse starts the processor on the bank that just filled. The processor reads samples from the bank not being written, using its own sample pointer.

## Interface
Parameters:
- SAMPLE_SIZE, 24, bits per stored sample.
- IO_BUFF_SIZE, 64, samples per chunk (per bank); power of two.
- IO_BUFF_PTR_BITS, $clog2(IO_BUFF_SIZE), pointer width.
- CHANNEL, 0, channel captured: 0 = left (lrclk low), 1 = right (lrclk high).

Ports:
- clk  in  1  system clock; single clock domain; clk ≥ 8× bclk.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable, synchronous to clk.
- i2s_bclk  in  1  I2S bit clock; asynchronous to clk.
- i2s_lrclk  in  1  I2S word select; asynchronous to clk.
- i2s_sdata  in  1  I2S serial data; asynchronous to clk.
- proc_busy  in  1  downstream processor still working on the previous chunk; tie to 0 if unused.
- chunk_pulse  out  1  one-cycle pulse: a bank has filled and is now the read bank.
- input_buff_ptr  in  IO_BUFF_PTR_BITS  read address within the read bank.
- input_buff_sample  out  SAMPLE_SIZE  registered read data.
- read_bank  out  1  index of the bank currently presented for reading.
- overrun  out  1  sticky flag: a bank swap occurred while proc_busy = 1.

## Operation
- All three I2S inputs pass through 2-flop synchronisers.
- Edges of the synchronised bclk are detected in the clk domain.
- Data is captured on bclk rising edges, Philips format:
  - MSB arrives one bclk after the lrclk transition; bits are MSB first.
  - The first SAMPLE_SIZE bits of a slot are kept; further bits are ignored.
  - If a slot is shorter than SAMPLE_SIZE, the missing LSBs are zero.
- A slot's word completes at the lrclk transition that ends the slot. Only words of slot CHANNEL are written.
- States:
  - IDLE: no writes; wr_ptr = 0. Leave for SYNC when enable = 1.
  - SYNC: discard data until the lrclk transition that begins a CHANNEL slot, then go to CAPTURE. This guarantees no partial first word.
  - CAPTURE: each completed CHANNEL word is written to write bank (= ~read_bank) at wr_ptr, and wr_ptr increments.
- Bank fill: when the write lands at wr_ptr = IO_BUFF_SIZE-1:
  - wr_ptr wraps to 0;
  - read_bank toggles;
  - chunk_pulse fires;
  - overrun is set if proc_busy = 1;
  - capture continues into the other bank with no dropped word.
- enable = 0 in any state: go to IDLE on the next cycle.
  - The partial chunk is discarded and wr_ptr is cleared.
  - read_bank, buffer contents and overrun are kept.
  - No chunk_pulse is issued.
- overrun is cleared only by reset.
- The read port always addresses bank read_bank. The write bank is never readable.

## Timing
- Reset values:
  - chunk_pulse = 0, input_buff_sample = 0, read_bank = 1 (bank 0 is the first write bank), overrun = 0;
  - state = IDLE, wr_ptr = 0, shift register = 0.
- Memory contents are not reset.
- Input latency: 3 clk cycles from a pin edge to edge detection (2 sync + 1 edge register).
- A word is written 1 clk cycle after detection of its terminating lrclk edge.
- chunk_pulse is high for exactly 1 cycle: the cycle after the final write of a bank.
  - read_bank changes on the same edge that raises chunk_pulse.
- Read latency:
  - input_buff_sample is valid 1 cycle after input_buff_ptr changes.
  - On the cycle chunk_pulse is high, input_buff_sample already reflects the new read bank at the current pointer.
- If enable falls on the cycle the final write would occur, the write is suppressed and no pulse is issued. enable = 0 takes priority.
- Asynchronous reset mid-chunk: all registers return to their reset values immediately; the next chunk restarts in bank 0.

## Structure
- Shared package dsp_common_pkg:
  - capture state encodings (IDLE/SYNC/CAPTURE);
  - channel encodings (CH_LEFT = 0, CH_RIGHT = 1);
  - default SAMPLE_SIZE and IO_BUFF_SIZE.
- Sub-module i2s_rx_deser:
  - contains the synchronisers, bclk/lrclk edge detection and the shift register;
  - outputs word[SAMPLE_SIZE-1:0], word_valid (1 cycle), word_channel and slot_start.
- Top level holds:
  - the FSM;
  - wr_ptr and bank logic;
  - a 2·IO_BUFF_SIZE × SAMPLE_SIZE memory with one synchronous write port and one registered read port (address = {read_bank, input_buff_ptr}).

## Test plan
- Reset, then enable, then 64 left words 0x000001…0x000040 → one chunk_pulse after the 64th write; read_bank = 0; reads at ptr 0 and 63 return 0x000001 and 0x000040, each one cycle after ptr is applied.
- Continuous stream of 128 words → two pulses 64 words apart; read_bank sequence 1→0→1; no word lost at the swap (word 65 is found in bank 1, ptr 0).
- Enable asserted mid-left-slot → the partial word is discarded; the first stored word is the next complete left word. Right-slot data 0xABCDEF is never stored with CHANNEL = 0.
- 32-bit slots carrying 0x123456FF → 0x123456 stored. 16-bit slots carrying 0xBEEF → 0xBEEF00 stored.
- proc_busy = 1 at the second swap → overrun = 1 and stays set after proc_busy falls. Enable dropped after 40 words → no pulse; re-enable starts at wr_ptr 0.
- rst_n asserted at word 30 → outputs return to their reset values immediately; after release, the first pulse comes after 64 new words.
